bf_mem_dp: RTL and testbench
============================

Name: bf_mem_dp

Overview:
- Parametrised successor to the bfX unified code/data memory.
- Two ports on one array:
  - Port A: read/write, data tape, addressed relative to the data region with wrap-around.
  - Port B: read-only instruction fetch from the code region, with out-of-bounds flag.
- After reset, an internal sequencer zero-fills the whole array, then accepts a program over a valid/ready load stream, then enters RUN, where both ports are live.

Parameters:
- DATA_W, 8, cell and instruction width in bits.
- ADDR_W, 16, width of both address ports.
- CODE_DEPTH, 256, code-region words at physical 0..CODE_DEPTH-1.
- DATA_DEPTH, 256, data-region words at physical CODE_DEPTH..CODE_DEPTH+DATA_DEPTH-1; must be a power of 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  program word offered.
- load_data  in  DATA_W  program word.
- load_last  in  1  qualifies final program word.
- load_ready  out  1  sequencer accepting program words.
- run  out  1  high in RUN; ports A/B serviced.
- load_overflow  out  1  sticky: a word was offered beyond CODE_DEPTH.
- a_en  in  1  port A access enable.
- a_we  in  1  port A write enable (valid only with a_en).
- a_addr  in  ADDR_W  data-tape offset.
- a_wdata  in  DATA_W  write data.
- a_rdata  out  DATA_W  registered read data.
- b_en  in  1  fetch enable.
- b_addr  in  ADDR_W  instruction address.
- b_rdata  out  DATA_W  registered instruction.
- b_oob  out  1  registered: last fetch was at or above CODE_DEPTH.

Behaviour:
- Reset (async, any state): state=CLEAR, counter=0.
  - a_rdata=0, b_rdata=0, b_oob=0, load_ready=0, run=0, load_overflow=0.
  - Array contents are not reset directly; CLEAR overwrites them.
- CLEAR:
  - Writes 0 to physical address counter each cycle; counter increments.
  - After address CODE_DEPTH+DATA_DEPTH-1 is written: counter=0, state=LOAD.
  - Duration is exactly CODE_DEPTH+DATA_DEPTH cycles. A/B requests are ignored.
- LOAD:
  - load_ready=1.
  - On load_valid&load_ready:
    - If counter<CODE_DEPTH, write load_data to physical counter and increment counter.
    - Otherwise drop the word and set load_overflow.
  - If load_last is in the same handshake, the next state is RUN.
  - Unloaded code words remain 0.
  - load_valid without load_last keeps LOAD indefinitely.
- RUN:
  - load_ready=0; load inputs ignored. run=1 from the cycle after the last handshake.
  - Stays in RUN until rst.
- Port A, only in RUN with a_en:
  - Physical address = CODE_DEPTH + (a_addr mod DATA_DEPTH), i.e. the low log2(DATA_DEPTH) bits, giving tape wrap-around.
  - With a_we: write a_wdata; a_rdata returns a_wdata on the next edge (write-first).
  - Read latency is 1 cycle.
  - With a_en=0 or outside RUN: a_rdata holds its value and no write occurs.
- Port B, only in RUN with b_en:
  - If b_addr<CODE_DEPTH: b_rdata=mem[b_addr], b_oob=0.
  - Otherwise: b_rdata=0, b_oob=1.
  - Latency 1 cycle. Port B never writes.
  - With b_en=0: b_rdata and b_oob hold.
- Port collision: port A writes only the data region and port B reads only the code region, so same-cycle collisions cannot occur. No forwarding is needed.
- Widths: address comparisons are unsigned across the full ADDR_W; bits of a_addr above the data-index width are ignored.

Test Plan:
1. Reset, idle 511 cycles -> load_ready=0. Cycle 512 -> load_ready=1. Then one handshake with data 8'h2B and load_last=1 -> run=1. Fetch b_addr=0 -> b_rdata=8'h2B. Fetch b_addr=1 -> 8'h00.
2. Load 257 words with load_last on the 257th -> load_overflow=1 and run=1. Fetch b_addr=255 returns word 255. Fetch b_addr=256 -> b_rdata=0, b_oob=1.
3. In RUN: write a_addr=3, 8'hFF, a_we=1 -> next-cycle a_rdata=8'hFF. Read a_addr=16'h0103 -> 8'hFF (wrap). Read a_addr=4 -> 8'h00.
4. Write a_addr=0, 8'h55; then hold a_en=0 for 3 cycles with a_addr changing -> a_rdata stays 8'h55.
5. Assert rst mid-LOAD after 10 words -> outputs go 0 immediately (async). After re-clear, a fetch of address 5 in a fresh RUN returns the newly loaded word, not the stale one.
6. Outside RUN, pulse a_en/a_we to a_addr=7, 8'hAA during CLEAR. Then in RUN read a_addr=7 -> 8'h00.

Source files
------------

// File: rtl/bf_mem_dp_if.sv
// Load stream, data-tape port (A) and instruction-fetch port (B) of bf_mem_dp.
// master drives requests; slave is the memory.
interface bf_mem_dp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              run;
  logic              load_overflow;

  logic              a_en;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;

  logic              b_en;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_rdata;
  logic              b_oob;

  modport master (
    output load_valid, load_data, load_last,
    output a_en, a_we, a_addr, a_wdata,
    output b_en, b_addr,
    input  load_ready, run, load_overflow,
    input  a_rdata, b_rdata, b_oob
  );

  modport slave (
    input  load_valid, load_data, load_last,
    input  a_en, a_we, a_addr, a_wdata,
    input  b_en, b_addr,
    output load_ready, run, load_overflow,
    output a_rdata, b_rdata, b_oob
  );
endinterface

// File: rtl/bf_mem_dp.sv
// Unified code/data memory: zero-fill, program load over valid/ready, then RUN with tape port A and fetch port B.
// Both ports have 1-cycle registered reads; load_ready is high only in LOAD and never stalls a handshake there.
module bf_mem_dp #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int CODE_DEPTH = 256,
  parameter int DATA_DEPTH = 256
) (
  input logic        clk,
  input logic        rst,
  bf_mem_dp_if.slave bus
);
  localparam int TOTAL = CODE_DEPTH + DATA_DEPTH;
  localparam int PA_W  = $clog2(TOTAL);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int DI_W  = $clog2(DATA_DEPTH);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  CNT_CODE = CNT_W'(CODE_DEPTH);
  localparam logic [ADDR_W:0]   B_LIM    = (ADDR_W + 1)'(CODE_DEPTH);
  localparam logic [PA_W-1:0]   A_BASE   = PA_W'(CODE_DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0]  mem [0:TOTAL-1];

  logic               mem_we;
  logic [PA_W-1:0]    mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               ovf_set;
  logic               load_hs;
  logic               in_run;
  logic               a_go;
  logic               b_go;
  logic               b_in_code;
  logic [PA_W-1:0]    a_phys;
  logic [PA_W-1:0]    b_idx;

  logic [DATA_W-1:0]  a_rdata_q;
  logic [DATA_W-1:0]  b_rdata_q;
  logic               b_oob_q;
  logic               ovf_q;

  logic               unused_a_hi;

  // Tape wrap-around: only the low DI_W offset bits select the data cell.
  assign a_phys      = A_BASE + PA_W'(bus.a_addr[DI_W-1:0]);
  assign unused_a_hi = ^bus.a_addr;

  assign b_in_code = ({1'b0, bus.b_addr} < B_LIM);
  assign b_idx     = PA_W'(bus.b_addr);

  assign in_run  = (state_q == S_RUN);
  assign load_hs = bus.load_valid && (state_q == S_LOAD);
  assign a_go    = in_run && bus.a_en;
  assign b_go    = in_run && bus.b_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = a_phys;
    mem_wdata = bus.a_wdata;
    ovf_set   = 1'b0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = PA_W'(cnt_q);
        mem_wdata = '0;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (load_hs) begin
          // Words past the code region are dropped but still end the load on load_last.
          if (cnt_q < CNT_CODE) begin
            mem_we    = 1'b1;
            mem_addr  = PA_W'(cnt_q);
            mem_wdata = bus.load_data;
            cnt_d     = cnt_q + 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
          if (bus.load_last) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        mem_we = bus.a_en && bus.a_we;
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Port A is write-first; port B only ever reads the code region so it never sees A's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      b_oob_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (a_go) begin
        a_rdata_q <= bus.a_we ? bus.a_wdata : mem[a_phys];
      end
      if (b_go) begin
        b_rdata_q <= b_in_code ? mem[b_idx] : '0;
        b_oob_q   <= !b_in_code;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.load_ready    = (state_q == S_LOAD);
  assign bus.run           = in_run;
  assign bus.load_overflow = ovf_q;
  assign bus.a_rdata       = a_rdata_q;
  assign bus.b_rdata       = b_rdata_q;
  assign bus.b_oob         = b_oob_q;
endmodule

// File: tb/tb_bf_mem_dp.sv
// Randomised bench for bf_mem_dp against a code-list / tape-array reference model.
module tb_bf_mem_dp;
  logic clk;
  logic rst;

  bf_mem_dp_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  bf_mem_dp #(
    .DATA_W(8), .ADDR_W(16), .CODE_DEPTH(256), .DATA_DEPTH(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Reference model: program as a list of loaded words, tape as a plain array.
  logic [7:0] m_code [256];
  logic [7:0] m_tape [256];
  int         m_len;
  bit         m_ovf;
  bit         m_run;
  logic [7:0] m_a;
  logic [7:0] m_b;
  bit         m_oob;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_code[i] = 8'h00;
      m_tape[i] = 8'h00;
    end
    m_len = 0;
    m_ovf = 0;
    m_run = 0;
    m_a   = 8'h00;
    m_b   = 8'h00;
    m_oob = 0;
  endtask

  task automatic do_reset(input bit wait_clear);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.a_en       = 1'b0;
    bus.a_we       = 1'b0;
    bus.b_en       = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_a_rdata", 16'(bus.a_rdata), 16'h0);
    chk("rst_b_rdata", 16'(bus.b_rdata), 16'h0);
    chk("rst_b_oob", 16'(bus.b_oob), 16'h0);
    chk("rst_load_ready", 16'(bus.load_ready), 16'h0);
    chk("rst_run", 16'(bus.run), 16'h0);
    chk("rst_load_overflow", 16'(bus.load_overflow), 16'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    if (wait_clear) begin
      repeat (512) @(negedge clk);
    end
  endtask

  task automatic load_word(input logic [7:0] d, input bit last);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk("load_ready", 16'(bus.load_ready), 16'h1);
    chk("run_pre", 16'(bus.run), 16'h0);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    if (m_len < 256) begin
      m_code[m_len] = d;
      m_len++;
    end else begin
      m_ovf = 1;
    end
    if (last) m_run = 1;
    chk("run", 16'(bus.run), 16'(m_run));
    chk("load_overflow", 16'(bus.load_overflow), 16'(m_ovf));
  endtask

  task automatic load_random(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      load_word(8'($urandom), last && (i == n - 1));
    end
  endtask

  task automatic cyc(input bit ae, input bit aw, input logic [15:0] aa, input logic [7:0] ad,
                     input bit be, input logic [15:0] ba);
    int idx;
    bus.a_en    = ae;
    bus.a_we    = aw;
    bus.a_addr  = aa;
    bus.a_wdata = ad;
    bus.b_en    = be;
    bus.b_addr  = ba;
    @(negedge clk);
    bus.a_en = 1'b0;
    bus.a_we = 1'b0;
    bus.b_en = 1'b0;
    if (m_run && ae) begin
      idx = int'(aa) % 256;
      if (aw) m_tape[idx] = ad;
      m_a = m_tape[idx];
    end
    if (m_run && be) begin
      if (int'(ba) < 256) begin
        m_b   = m_code[int'(ba)];
        m_oob = 0;
      end else begin
        m_b   = 8'h00;
        m_oob = 1;
      end
    end
    chk("a_rdata", 16'(bus.a_rdata), 16'(m_a));
    chk("b_rdata", 16'(bus.b_rdata), 16'(m_b));
    chk("b_oob", 16'(bus.b_oob), 16'(m_oob));
  endtask

  task automatic random_ops(input int n);
    bit         ae, aw, be;
    logic [15:0] aa, ba;
    logic [7:0]  ad;
    for (int i = 0; i < n; i++) begin
      ae = ($urandom_range(0, 3) != 0);
      aw = ($urandom_range(0, 1) != 0);
      aa = 16'($urandom);
      ad = 8'($urandom);
      be = ($urandom_range(0, 3) != 0);
      ba = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
      cyc(ae, aw, aa, ad, be, ba);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst            = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_last  = 1'b0;
    bus.a_en       = 1'b0;
    bus.a_we       = 1'b0;
    bus.a_addr     = 16'h0;
    bus.a_wdata    = 8'h00;
    bus.b_en       = 1'b0;
    bus.b_addr     = 16'h0;
    @(negedge clk);

    // Clear timing, with a port A write attempted during CLEAR.
    do_reset(1'b0);
    cyc(1'b1, 1'b1, 16'd7, 8'hAA, 1'b1, 16'd0);
    repeat (510) @(negedge clk);
    chk("clear_511_load_ready", 16'(bus.load_ready), 16'h0);
    @(negedge clk);
    chk("clear_512_load_ready", 16'(bus.load_ready), 16'h1);
    load_word(8'h2B, 1'b1);
    chk("run_load_ready", 16'(bus.load_ready), 16'h0);
    cyc(1'b0, 1'b0, 16'd0, 8'h00, 1'b1, 16'd0);
    chk("fetch0_2b", 16'(bus.b_rdata), 16'h2B);
    cyc(1'b0, 1'b0, 16'd0, 8'h00, 1'b1, 16'd1);
    cyc(1'b1, 1'b0, 16'd7, 8'h00, 1'b0, 16'd0);
    chk("clear_write_ignored", 16'(bus.a_rdata), 16'h00);

    // Overflowing load and fetch at the code boundary.
    do_reset(1'b1);
    load_random(257, 1'b1);
    chk("ovf_sticky", 16'(bus.load_overflow), 16'h1);
    cyc(1'b0, 1'b0, 16'd0, 8'h00, 1'b1, 16'd255);
    cyc(1'b0, 1'b0, 16'd0, 8'h00, 1'b1, 16'd256);
    chk("oob_256", 16'(bus.b_oob), 16'h1);
    cyc(1'b0, 1'b0, 16'd0, 8'h00, 1'b1, 16'hFFFF);

    // Tape write-first, wrap-around and hold.
    cyc(1'b1, 1'b1, 16'd3, 8'hFF, 1'b0, 16'd0);
    chk("write_first_ff", 16'(bus.a_rdata), 16'hFF);
    cyc(1'b1, 1'b0, 16'h0103, 8'h00, 1'b0, 16'd0);
    chk("wrap_0103", 16'(bus.a_rdata), 16'hFF);
    cyc(1'b1, 1'b0, 16'd4, 8'h00, 1'b0, 16'd0);
    cyc(1'b1, 1'b1, 16'd0, 8'h55, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 16'(i * 37 + 1), 8'h12, 1'b0, 16'd0);
      chk("hold_55", 16'(bus.a_rdata), 16'h55);
    end
    random_ops(300);

    // Reset from RUN, then again mid-LOAD; the fresh program must replace the old one.
    cyc(1'b1, 1'b1, 16'd9, 8'hC3, 1'b1, 16'd5);
    do_reset(1'b1);
    load_random(10, 1'b0);
    cyc(1'b1, 1'b1, 16'd2, 8'h77, 1'b1, 16'd3);
    do_reset(1'b1);
    load_random(12, 1'b1);
    cyc(1'b0, 1'b0, 16'd0, 8'h00, 1'b1, 16'd5);
    cyc(1'b0, 1'b0, 16'd0, 8'h00, 1'b1, 16'd12);
    cyc(1'b1, 1'b0, 16'd9, 8'h00, 1'b0, 16'd0);
    random_ops(150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
